// File: rtl/periph_bus_arbiter_pkg.sv
// Shared types, constants and helpers for the peripheral bus arbiter and its
// select decoder.
package periph_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } master_e;

  localparam int unsigned IDX_W     = 5;
  localparam logic [31:0] ERR_RDATA = 32'h0000_0000;

  function automatic logic [IDX_W-1:0] dev_idx(input logic [31:0] addr,
                                               input int unsigned lsb);
    return addr[lsb +: IDX_W];
  endfunction

  // Round-robin pick between two masters; a locked previous owner keeps the bus
  // only while it is still requesting.
  function automatic master_e rr_pick(input logic    req0,
                                      input logic    req1,
                                      input logic    lock_prev,
                                      input master_e last);
    master_e pick;
    if (req0 && req1) begin
      if (lock_prev) begin
        pick = last;
      end else begin
        pick = (last == M0) ? M1 : M0;
      end
    end else if (req1) begin
      pick = M1;
    end else begin
      pick = M0;
    end
    return pick;
  endfunction

endpackage

// File: rtl/periph_bus_arbiter_sel_decode.sv
// Device index to one-hot select decoder; indices at or above NUM_SEL decode to
// no select and flag an error.
module periph_bus_arbiter_sel_decode
  import periph_bus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_SEL = 32
) (
  input  logic [IDX_W-1:0] idx_i,
  output logic [31:0]      sel_o,
  output logic             err_o
);

  // Range check and one-hot expansion of the device index.
  always_comb begin
    sel_o = 32'h0000_0000;
    err_o = 1'b0;
    if ({27'd0, idx_i} < 32'(NUM_SEL)) begin
      sel_o = 32'd1 << idx_i;
    end else begin
      err_o = 1'b1;
    end
  end

endmodule

// File: rtl/periph_bus_arbiter.sv
// Two-master arbiter for the peripheral bus: picks an owner, drives the decoded
// access for a fixed wait window, then returns read data with a done pulse.
module periph_bus_arbiter
  import periph_bus_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned SEL_LSB     = 8,
  parameter int unsigned NUM_SEL     = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m1_req,
  input  logic        m0_w,
  input  logic        m1_w,
  input  logic        m0_lock,
  input  logic        m1_lock,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m0_wdata,
  input  logic [31:0] m1_wdata,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_done,
  output logic        m1_done,
  output logic        m0_err,
  output logic        m1_err,
  output logic [31:0] m0_rdata,
  output logic [31:0] m1_rdata,
  output logic [31:0] bus_select,
  output logic        bus_w,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_data,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned    CNT_W    = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  master_e           owner_q, owner_d, last_q, last_d, win_s;
  logic              lock_q, lock_d;
  logic              acc_w_q, acc_w_d, acc_err_q, acc_err_d;
  logic [1:0]        gnt_q, gnt_d, done_q, done_d, err_q, err_d;
  logic [1:0][31:0]  rdata_q, rdata_d;
  logic [31:0]       sel_q, sel_d, addr_q, addr_d, data_q, data_d;
  logic              w_q, w_d;

  logic [1:0]        req_s, w_s, lock_s;
  logic [1:0][31:0]  addr_s, wdata_s;
  logic [IDX_W-1:0]  win_idx_s;
  logic [31:0]       dec_sel_s;
  logic              dec_err_s;

  assign req_s   = {m1_req, m0_req};
  assign w_s     = {m1_w, m0_w};
  assign lock_s  = {m1_lock, m0_lock};
  assign addr_s  = {m1_addr, m0_addr};
  assign wdata_s = {m1_wdata, m0_wdata};

  assign win_s     = rr_pick(m0_req, m1_req, lock_q, last_q);
  assign win_idx_s = dev_idx(addr_s[win_s], SEL_LSB);

  periph_bus_arbiter_sel_decode #(.NUM_SEL(NUM_SEL)) u_sel_decode (
    .idx_i (win_idx_s),
    .sel_o (dec_sel_s),
    .err_o (dec_err_s)
  );

  // Next-state and next-output logic; the access is latched at grant so a
  // master dropping req mid-access cannot disturb the bus.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    last_d    = last_q;
    lock_d    = lock_q;
    acc_w_d   = acc_w_q;
    acc_err_d = acc_err_q;
    gnt_d     = 2'b00;
    done_d    = 2'b00;
    err_d     = 2'b00;
    rdata_d   = rdata_q;
    sel_d     = 32'h0000_0000;
    w_d       = 1'b0;
    addr_d    = 32'h0000_0000;
    data_d    = 32'h0000_0000;
    case (state_q)
      ST_IDLE: begin
        if (|req_s) begin
          state_d        = ST_ACCESS;
          cnt_d          = {CNT_W{1'b0}};
          owner_d        = win_s;
          acc_w_d        = w_s[win_s];
          acc_err_d      = dec_err_s;
          gnt_d[win_s]   = 1'b1;
          sel_d          = dec_sel_s;
          w_d            = w_s[win_s] & ~dec_err_s;
          addr_d         = addr_s[win_s];
          data_d         = wdata_s[win_s];
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        gnt_d[owner_q] = 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d         = ST_RESP;
          done_d[owner_q] = 1'b1;
          err_d[owner_q]  = acc_err_q;
          rdata_d[owner_q] = (acc_w_q | acc_err_q) ? ERR_RDATA : bus_rdata;
        end else begin
          cnt_d  = cnt_q + CNT_W'(1'b1);
          sel_d  = sel_q;
          addr_d = addr_q;
          data_d = data_q;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        last_d  = owner_q;
        lock_d  = lock_s[owner_q];
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, arbitration history and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      owner_q   <= M0;
      last_q    <= M1;
      lock_q    <= 1'b0;
      acc_w_q   <= 1'b0;
      acc_err_q <= 1'b0;
      gnt_q     <= 2'b00;
      done_q    <= 2'b00;
      err_q     <= 2'b00;
      rdata_q   <= {2{32'h0000_0000}};
      sel_q     <= 32'h0000_0000;
      w_q       <= 1'b0;
      addr_q    <= 32'h0000_0000;
      data_q    <= 32'h0000_0000;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      lock_q    <= lock_d;
      acc_w_q   <= acc_w_d;
      acc_err_q <= acc_err_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      sel_q     <= sel_d;
      w_q       <= w_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
    end
  end

  assign m0_gnt     = gnt_q[M0];
  assign m1_gnt     = gnt_q[M1];
  assign m0_done    = done_q[M0];
  assign m1_done    = done_q[M1];
  assign m0_err     = err_q[M0];
  assign m1_err     = err_q[M1];
  assign m0_rdata   = rdata_q[M0];
  assign m1_rdata   = rdata_q[M1];
  assign bus_select = sel_q;
  assign bus_w      = w_q;
  assign bus_addr   = addr_q;
  assign bus_data   = data_q;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Self-checking bench: vector table, hand sequences for arbitration/reset corners,
// and random traffic checked every cycle against a transaction-phase model.
`timescale 1ns/1ps
module tb_periph_bus_arbiter;

  localparam int          W      = 2;
  localparam int          NSEL   = 8;
  localparam int          IDLE_P = W + 3;
  localparam logic [31:0] K      = 32'hC0DE_F00D;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m1_req, m0_w, m1_w, m0_lock, m1_lock;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err;
  logic [31:0] m0_rdata, m1_rdata, bus_select, bus_addr, bus_data, bus_rdata;
  logic        bus_w;
  logic        use_fixed = 1'b1;
  logic [31:0] fixed_rdata = 32'h0;
  logic        chk_en = 1'b0;
  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;

  assign bus_rdata = use_fixed ? fixed_rdata : (bus_addr ^ K);
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  periph_bus_arbiter #(.WAIT_CYCLES(W), .SEL_LSB(8), .NUM_SEL(NSEL)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m1_req(m1_req), .m0_w(m0_w), .m1_w(m1_w),
    .m0_lock(m0_lock), .m1_lock(m1_lock),
    .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_done(m0_done), .m1_done(m1_done),
    .m0_err(m0_err), .m1_err(m1_err), .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .bus_select(bus_select), .bus_w(bus_w), .bus_addr(bus_addr), .bus_data(bus_data),
    .bus_rdata(bus_rdata)
  );

  // ---------------- reference model: phase = cycles since the grant edge
  int          p = IDLE_P;
  logic        own = 1'b0, last = 1'b1, lockp = 1'b0, w_own = 1'b0, e_own = 1'b0;
  logic [31:0] a_own = 32'h0, d_own = 32'h0;
  logic [31:0] rd_exp [2] = '{32'h0, 32'h0};
  logic        mwin;

  function automatic logic pick(input logic r0, input logic r1, input logic lk, input logic lst);
    if (r0 && r1) return lk ? lst : ~lst;
    return r1;
  endfunction
  function automatic logic is_err(input logic [31:0] a);
    return ((a >> 8) & 32'h1F) >= NSEL;
  endfunction
  function automatic logic [31:0] sel_of(input logic [31:0] a);
    return 32'd1 << ((a >> 8) & 32'h1F);
  endfunction
  function automatic logic [31:0] periph(input logic [31:0] a);
    return use_fixed ? fixed_rdata : (a ^ K);
  endfunction

  assign mwin = pick(m0_req, m1_req, lockp, last);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      p <= IDLE_P; own <= 1'b0; last <= 1'b1; lockp <= 1'b0;
      w_own <= 1'b0; e_own <= 1'b0; a_own <= 32'h0; d_own <= 32'h0;
      rd_exp[0] <= 32'h0; rd_exp[1] <= 32'h0;
    end else if (p >= IDLE_P) begin
      if (m0_req || m1_req) begin
        p     <= 1;
        own   <= mwin;
        a_own <= mwin ? m1_addr : m0_addr;
        d_own <= mwin ? m1_wdata : m0_wdata;
        w_own <= mwin ? m1_w : m0_w;
        e_own <= is_err(mwin ? m1_addr : m0_addr);
      end
    end else begin
      p <= p + 1;
      if (p == W + 1) rd_exp[own] <= (w_own || e_own) ? 32'h0 : periph(a_own);
      if (p == W + 2) begin
        last  <= own;
        lockp <= own ? m1_lock : m0_lock;
      end
    end
  end

  task automatic check_cycle();
    logic [1:0]   g, d, e;
    logic [31:0]  s, ad, dt;
    logic         bw;
    logic [166:0] act, exp_v;
    g = 2'b0; d = 2'b0; e = 2'b0; s = 32'h0; ad = 32'h0; dt = 32'h0; bw = 1'b0;
    if (p >= 1 && p <= W + 1) begin
      g[own] = 1'b1; ad = a_own; dt = d_own;
      s  = e_own ? 32'h0 : sel_of(a_own);
      bw = (p == 1) && w_own && !e_own;
    end else if (p == W + 2) begin
      g[own] = 1'b1; d[own] = 1'b1; e[own] = e_own;
    end
    exp_v = {g, d, e, s, bw, ad, dt, rd_exp[1], rd_exp[0]};
    act   = {m1_gnt, m0_gnt, m1_done, m0_done, m1_err, m0_err, bus_select, bus_w,
             bus_addr, bus_data, m1_rdata, m0_rdata};
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL cycle@%0t act=%h exp=%h", $time, act, exp_v);
    end
  endtask

  always @(negedge clk) if (chk_en) check_cycle();

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s act=%h exp=%h", name, act, exp_v);
    end
  endtask

  // ---------------- vector table
  typedef struct {
    logic        m;
    logic        w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdfix;
    logic [31:0] exp_sel;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t vecs [6];

  task automatic run_vec(input vec_t v);
    int          lat, wcnt;
    logic        sel_ok, got_err;
    logic [31:0] seen_data, got_rd;
    lat = 0; wcnt = 0; sel_ok = 1'b1; got_err = 1'b0; seen_data = 32'h0; got_rd = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    use_fixed = 1'b1; fixed_rdata = v.rdfix;
    if (v.m) begin m1_w = v.w; m1_addr = v.addr; m1_wdata = v.wdata; m1_req = 1'b1; end
    else     begin m0_w = v.w; m0_addr = v.addr; m0_wdata = v.wdata; m0_req = 1'b1; end
    @(posedge clk);
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge clk);
      if (k <= W + 1) begin
        if (bus_select !== v.exp_sel) sel_ok = 1'b0;
        if (k == 1) seen_data = bus_data;
      end
      if (bus_w) wcnt++;
      if (v.m ? m1_done : m0_done) begin
        lat = k; got_err = v.m ? m1_err : m0_err; got_rd = v.m ? m1_rdata : m0_rdata;
      end
    end
    @(posedge clk); #1;
    m0_req = 1'b0; m1_req = 1'b0;
    chk("vec_latency", lat, W + 2);
    chk("vec_select", sel_ok, 1);
    chk("vec_strobe_count", wcnt, (v.w && !v.exp_err) ? 1 : 0);
    chk("vec_err", got_err, v.exp_err);
    chk("vec_rdata", got_rd, v.exp_rdata);
    if (v.w) chk("vec_bus_data", seen_data, v.wdata);
  endtask

  task automatic wait_done(output int who, output int at);
    who = -1; at = 0;
    for (int k = 0; k < 40 && who < 0; k++) begin
      @(negedge clk);
      if (m0_done) begin who = 0; at = cyc; end
      else if (m1_done) begin who = 1; at = cyc; end
    end
    if (who < 0) begin
      n_tests++; n_fail++;
      $display("FAIL done_timeout act=none exp=done");
    end
  endtask

  task automatic do_reset();
    @(negedge clk); #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
  endtask

  int   who, at, prev, dcnt;
  logic pend0, pend1, d0, d1, seen;

  initial begin
    rst = 1'b0;
    m0_req = 1'b0; m1_req = 1'b0; m0_w = 1'b0; m1_w = 1'b0; m0_lock = 1'b0; m1_lock = 1'b0;
    m0_addr = 32'h0; m1_addr = 32'h0; m0_wdata = 32'h0; m1_wdata = 32'h0;
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0300, 32'h0,         32'h1234_5678, 32'h0000_0008, 1'b0, 32'h1234_5678};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_0100, 32'hA5A5_A5A5, 32'hDEAD_0001, 32'h0000_0002, 1'b0, 32'h0};
    vecs[2] = '{1'b0, 1'b0, 32'h0000_1F00, 32'h0,         32'h7777_7777, 32'h0000_0000, 1'b1, 32'h0};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0700, 32'h0,         32'hCAFE_BABE, 32'h0000_0080, 1'b0, 32'hCAFE_BABE};
    vecs[4] = '{1'b1, 1'b1, 32'h0000_0800, 32'h1111_2222, 32'h3333_4444, 32'h0000_0000, 1'b1, 32'h0};
    vecs[5] = '{1'b0, 1'b1, 32'hFFFF_E0FC, 32'h0000_0001, 32'h5A5A_5A5A, 32'h0000_0001, 1'b0, 32'h0};
    #1 chk_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_ctl", {m1_gnt, m0_gnt, m1_done, m0_done, m1_err, m0_err, bus_w}, 64'h0);
    chk("reset_bus", {bus_select, bus_addr}, 64'h0);
    #2 rst = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // round-robin with both masters requesting continuously
    do_reset();
    @(posedge clk); #1;
    use_fixed = 1'b0;
    m0_addr = 32'h0000_0200; m0_w = 1'b0;
    m1_addr = 32'h0000_0410; m1_w = 1'b1; m1_wdata = 32'h5555_AAAA;
    m0_req = 1'b1; m1_req = 1'b1;
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      wait_done(who, at);
      chk("rr_order", who, i % 2);
      if (i > 0) chk("rr_spacing", at - prev, W + 3);
      prev = at;
    end

    // lock keeps m0 on the bus until its req drops
    @(posedge clk); #1 m0_lock = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_done(who, at);
      chk("lock_m0_held", who, 0);
    end
    @(posedge clk); #1 m0_req = 1'b0;
    wait_done(who, at);
    chk("lock_released_m1", who, 1);
    @(posedge clk); #1 m1_req = 1'b0; m0_lock = 1'b0;

    // owner drops req mid-access: access still completes
    @(posedge clk); #1 m1_req = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin @(negedge clk); seen = m1_gnt; end
    chk("drop_gnt_seen", seen, 1);
    @(posedge clk); #1 m1_req = 1'b0;
    wait_done(who, at);
    chk("drop_done", who, 1);

    // reset in the middle of an access
    run_vec(vecs[0]);
    @(posedge clk); #1 m0_req = 1'b1; m1_req = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin @(negedge clk); seen = m0_gnt | m1_gnt; end
    chk("prereset_owner_m1", {m1_gnt, m0_gnt}, 2'b10);
    @(posedge clk); #2 rst = 1'b0;
    #1;
    chk("midreset_ctl", {m1_gnt, m0_gnt, m1_done, m0_done, m1_err, m0_err, bus_w}, 64'h0);
    chk("midreset_bus", {bus_select, bus_data}, 64'h0);
    chk("midreset_rdata", {m1_rdata, m0_rdata}, 64'h0);
    dcnt = 0;
    repeat (3) begin @(negedge clk); if (m0_done || m1_done) dcnt++; end
    chk("midreset_no_done", dcnt, 0);
    #2 rst = 1'b1;
    wait_done(who, at);
    chk("postreset_m0_first", who, 0);
    @(posedge clk); #1 m0_req = 1'b0; m1_req = 1'b0;

    // random traffic; every cycle is checked against the model
    for (int r = 0; r < 40; r++) begin
      @(posedge clk); #1;
      use_fixed = 1'($urandom_range(0, 1)); fixed_rdata = $urandom;
      m0_addr = $urandom; m0_addr[12:8] = 5'($urandom_range(0, 11));
      m1_addr = $urandom; m1_addr[12:8] = 5'($urandom_range(0, 11));
      m0_wdata = $urandom; m1_wdata = $urandom;
      m0_w = 1'($urandom_range(0, 1)); m1_w = 1'($urandom_range(0, 1));
      pend0 = 1'($urandom_range(0, 1)); pend1 = 1'($urandom_range(0, 1));
      if (!pend0 && !pend1) pend0 = 1'b1;
      m0_req = pend0; m1_req = pend1;
      for (int k = 0; k < 60 && (pend0 || pend1); k++) begin
        @(negedge clk); d0 = m0_done; d1 = m1_done;
        @(posedge clk); #1;
        if (d0) begin m0_req = 1'b0; pend0 = 1'b0; end
        if (d1) begin m1_req = 1'b0; pend1 = 1'b0; end
        m0_lock = 1'($urandom_range(0, 1)); m1_lock = 1'($urandom_range(0, 1));
      end
      chk("rand_round_complete", {pend1, pend0}, 2'b00);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
